lcg_stim_gen: RTL and testbench
===============================

# lcg_stim_gen

Synthesizable, parametrised stimulus generator and response compactor for fuzz-style DUT exercise. It expands a 32-bit seed into wide stimulus frames with the 32-bit LCG the team uses for deterministic cross-simulator randomisation. It also folds DUT responses into a 32-bit signature, so runs compare by one word instead of full cycle traces. It sits between a run controller and a DUT wrapper exposing flat `in_flat`/`out_flat` buses.

## Interface

Parameters:
- `IN_W`, 260, stimulus width; `L = ceil(IN_W/32)` LCG words per frame
- `OUT_W`, 330, DUT response width
- `CNT_W`, 32, frame counter width

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous active-high reset
- `start`  in  1  begin run; sampled only in IDLE or DONE
- `seed`  in  32  LCG seed, captured on accepted `start`
- `cycles`  in  CNT_W  frames to apply, captured on accepted `start`
- `mode`  in  2  0 LCG, 1 walking-one, 2 alternating zeros/ones, 3 treated as 0; captured on `start`
- `resp`  in  OUT_W  DUT response
- `stim`  out  IN_W  current stimulus frame (drives DUT `in_flat`)
- `stim_valid`  out  1  one-cycle pulse: new frame applied this cycle
- `busy`  out  1  high in FILL/APPLY
- `done`  out  1  high in DONE
- `cyc_cnt`  out  CNT_W  frames applied so far
- `signature`  out  32  MISR over sampled responses

## Operation

- LCG step: `s' = (s * 32'h41C64E6D + 32'h3039) mod 2^32`.
- States: IDLE, FILL, APPLY, DONE.
- IDLE/DONE + `start`:
  - capture `seed`/`cycles`/`mode`; `rng = seed`; clear `cyc_cnt`, `signature` and `done`
  - go FILL, or go DONE if `cycles == 0`
- FILL: exactly L cycles. Word index k = 0..L-1 is built into a shadow register; `stim` is unchanged during FILL.
  - mode 0: `rng` steps once per cycle; word k = stepped value. The last word keeps its low `IN_W - 32*(L-1)` bits.
  - mode 1: frame n = bit `(n mod IN_W)` set, all others 0.
  - mode 2: frame n = all zeros for even n, all ones for odd n.
  - `rng` does not step in modes 1/2; timing is identical to mode 0.
- APPLY: one cycle.
  - On entry, `stim` <= shadow and `stim_valid` = 1 for this cycle.
  - On the APPLY clock edge, `signature <= {signature[30:0], signature[31]} ^ fold32(resp)`. `fold32` is the XOR of the 32-bit chunks of `resp`, zero-padded to a 32-bit multiple.
  - `cyc_cnt` increments on the same edge.
  - Next state: DONE if `cyc_cnt + 1 == cycles`, else FILL.
- The LCG sequence continues across frames: frame n+1 word 0 is the step after frame n's last word, matching the team's serial fill order.
- DONE: `stim`, `cyc_cnt` and `signature` hold; `done` = 1 until the next accepted `start`.
- `start` in FILL/APPLY is ignored.

## Timing

- Reset (async assert, sync-style deassert accepted): all outputs 0; state IDLE; `rng` 0.
- Reset mid-run aborts immediately; no partial frame is ever presented.
- `start` sampled on edge E:
  - `busy` = 1 from E+1
  - first `stim_valid` at cycle E+L+1
- Frame period L+1 cycles; total run `cycles*(L+1)` cycles from E+1 to DONE entry.
- `done` rises on the edge after the last APPLY; `busy` falls on the same edge.
- `resp` must be settled during the APPLY cycle. It reflects the previous frame if the DUT is registered; the controller accounts for this.
- `cyc_cnt` wraps modulo 2^CNT_W. With `cycles = 0` the run is length 0, so it never wraps in practice.
- `start` and `rst` together: reset wins.

## Test plan

- IN_W=40, seed=0, mode 0, cycles=1, start at edge 0 -> `stim_valid` at cycle 3, `stim = 40'h7E_00003039`, `cyc_cnt = 1`, `done = 1` at cycle 4, `busy` 0 at cycle 4.
- IN_W=40, mode 1, cycles=3 -> `stim` sequence 0x1, 0x2, 0x4; 3 `stim_valid` pulses spaced 3 cycles apart.
- OUT_W=64, `resp` tied to 64'h00000001_00000003, cycles=2 -> signature 0x2 after frame 1, 0x6 after frame 2.
- cycles=0 with start -> DONE on the next cycle, `cyc_cnt = 0`, no `stim_valid`, `stim` unchanged.
- Assert `rst` during the second FILL of a 4-frame run -> all outputs 0 immediately; a new `start` with seed=0 reproduces the first-test frame exactly.
- `start` pulsed while busy -> ignored: `cycles`/`seed` not recaptured, run length unchanged.

Source files
------------

// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: expands a 32-bit seed into wide stimulus frames and folds
// DUT responses into a 32-bit rotating signature.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FILL   | building one frame, one 32-bit word per cycle into the shadow
// APPLY  | frame presented on stim, response folded into signature
// DONE   | run complete, results held until the next start
module lcg_stim_gen #(
   parameter int IN_W  = 260,
   parameter int OUT_W = 330,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      seed,
   input  logic [CNT_W-1:0] cycles,
   input  logic [1:0]       mode,
   input  logic [OUT_W-1:0] resp,
   output logic [IN_W-1:0]  stim,
   output logic             stim_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [31:0]      signature
);

   localparam int L     = (IN_W + 31) / 32;
   localparam int OL    = (OUT_W + 31) / 32;
   localparam int IDX_W = (L > 1) ? $clog2(L) : 1;
   localparam int BP_W  = (IN_W > 1) ? $clog2(IN_W) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_APPLY,
      ST_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_rng;
   logic [CNT_W-1:0] r_cycles;
   logic [1:0]       r_mode;
   logic [IDX_W-1:0] r_widx;
   logic [BP_W-1:0]  r_bitpos;
   logic [IN_W-1:0]  r_shadow;
   logic [IN_W-1:0]  r_stim;
   logic [CNT_W-1:0] r_cyc_cnt;
   logic [31:0]      r_sig;

   logic             w_start_ok;
   logic             w_last_word;
   logic             w_last_frame;
   logic             w_lcg_mode;
   logic [31:0]      w_rng_step;
   logic [IN_W-1:0]  w_pat;
   logic [IN_W-1:0]  w_shadow_nxt;
   logic [32*OL-1:0] w_resp_pad;
   logic [31:0]      w_fold;

   function automatic logic [31:0] lcg_step(input logic [31:0] s);
      return s * 32'h41C64E6D + 32'h3039;
   endfunction

   assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_last_word  = (r_widx == IDX_W'(L - 1));
   assign w_last_frame = ((r_cyc_cnt + CNT_W'(1)) == r_cycles);
   // Mode 3 is an unused encoding and behaves like the LCG mode.
   assign w_lcg_mode   = (r_mode == 2'd0) || (r_mode == 2'd3);
   assign w_rng_step   = lcg_step(r_rng);

   // Whole-frame pattern for the deterministic modes; frame index is cyc_cnt.
   always_comb begin
      w_pat = '0;
      if (r_mode == 2'd1) begin
         w_pat[r_bitpos] = 1'b1;
      end else if (r_mode == 2'd2) begin
         if (r_cyc_cnt[0]) w_pat = '1;
      end
   end

   // Shadow with the current word merged in; stim loads from this on the
   // last FILL edge so the final word is not a cycle late.
   always_comb begin
      w_shadow_nxt = r_shadow;
      for (int i = 0; i < IN_W; i++) begin
         if (IDX_W'(i / 32) == r_widx) begin
            w_shadow_nxt[i] = w_lcg_mode ? w_rng_step[i % 32] : w_pat[i];
         end
      end
   end

   // XOR of the zero-padded 32-bit chunks of the response.
   always_comb begin
      w_resp_pad = '0;
      w_resp_pad[OUT_W-1:0] = resp;
      w_fold = '0;
      for (int j = 0; j < OL; j++) begin
         w_fold = w_fold ^ w_resp_pad[j*32 +: 32];
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_start_ok) w_next = (cycles == '0) ? ST_DONE : ST_FILL;
         end
         ST_FILL: begin
            if (w_last_word) w_next = ST_APPLY;
         end
         ST_APPLY: begin
            w_next = w_last_frame ? ST_DONE : ST_FILL;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Run configuration, frame build, stim, counter and signature.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rng     <= '0;
         r_cycles  <= '0;
         r_mode    <= '0;
         r_widx    <= '0;
         r_bitpos  <= '0;
         r_shadow  <= '0;
         r_stim    <= '0;
         r_cyc_cnt <= '0;
         r_sig     <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start_ok) begin
                  r_rng     <= seed;
                  r_cycles  <= cycles;
                  r_mode    <= mode;
                  r_widx    <= '0;
                  r_bitpos  <= '0;
                  r_cyc_cnt <= '0;
                  r_sig     <= '0;
               end
            end
            ST_FILL: begin
               r_shadow <= w_shadow_nxt;
               if (w_lcg_mode) r_rng <= w_rng_step;
               if (w_last_word) begin
                  r_widx <= '0;
                  r_stim <= w_shadow_nxt;
               end else begin
                  r_widx <= r_widx + IDX_W'(1);
               end
            end
            ST_APPLY: begin
               r_sig     <= {r_sig[30:0], r_sig[31]} ^ w_fold;
               r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
               if (r_bitpos == BP_W'(IN_W - 1)) r_bitpos <= '0;
               else                              r_bitpos <= r_bitpos + BP_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign stim       = r_stim;
   assign stim_valid = (r_state == ST_APPLY);
   assign busy       = (r_state == ST_FILL) || (r_state == ST_APPLY);
   assign done       = (r_state == ST_DONE);
   assign cyc_cnt    = r_cyc_cnt;
   assign signature  = r_sig;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Bench for lcg_stim_gen with a 40-bit stimulus and 64-bit response.
module tb_lcg_stim_gen;

   localparam int IN_W  = 40;
   localparam int OUT_W = 64;
   localparam int CNT_W = 32;
   localparam int L     = 2;

   logic             clk;
   logic             rst;
   logic             start;
   logic [31:0]      seed;
   logic [CNT_W-1:0] cycles;
   logic [1:0]       mode;
   logic [OUT_W-1:0] resp;
   logic [IN_W-1:0]  stim;
   logic             stim_valid;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] cyc_cnt;
   logic [31:0]      signature;

   int total = 0;
   int bad   = 0;
   logic [IN_W-1:0] last_stim;

   lcg_stim_gen #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .seed       (seed),
      .cycles     (cycles),
      .mode       (mode),
      .resp       (resp),
      .stim       (stim),
      .stim_valid (stim_valid),
      .busy       (busy),
      .done       (done),
      .cyc_cnt    (cyc_cnt),
      .signature  (signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] lcg(input logic [31:0] s);
      return s * 32'h41C64E6D + 32'h3039;
   endfunction

   // Runs one complete job and checks every cycle from E+1 to DONE entry.
   task automatic do_run(input logic [31:0] s, input logic [1:0] m, input int cyc,
                         input bit fix_resp, input int intr_k, input string tag);
      logic [IN_W-1:0] frames[$];
      logic [31:0]     rng;
      logic [63:0]     wide;
      logic [63:0]     r;
      logic [31:0]     esig;
      logic [IN_W-1:0] est;
      int              per, last_k, idx;
      bit              ap, eb, ed;
      per = L + 1;
      rng = s;
      frames.delete();
      for (int n = 0; n < cyc; n++) begin
         if (m == 2'd1) begin
            frames.push_back(40'd1 << (n % IN_W));
         end else if (m == 2'd2) begin
            frames.push_back((n % 2 == 1) ? {IN_W{1'b1}} : 40'd0);
         end else begin
            wide = '0;
            for (int k = 0; k < L; k++) begin
               rng = lcg(rng);
               wide[k*32 +: 32] = rng;
            end
            frames.push_back(wide[IN_W-1:0]);
         end
      end
      esig = '0;
      est  = last_stim;
      idx  = 0;
      @(negedge clk);
      seed = s; mode = m; cycles = cyc; start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      last_k = cyc * per + 1;
      for (int k = 1; k <= last_k; k++) begin
         ap = (cyc != 0) && (k % per == 0);
         eb = (cyc != 0) && (k < last_k);
         ed = (k == last_k);
         if (ap) begin
            idx = k / per - 1;
            est = frames[idx];
            total++;
            if (cyc_cnt !== 32'(idx)) begin
               bad++;
               $display("FAIL %s cyc_cnt@apply k=%0d: got %0d want %0d", tag, k, cyc_cnt, idx);
            end
         end
         total++;
         if (stim_valid !== ap) begin
            bad++;
            $display("FAIL %s stim_valid k=%0d: got %b want %b", tag, k, stim_valid, ap);
         end
         total++;
         if (busy !== eb) begin
            bad++;
            $display("FAIL %s busy k=%0d: got %b want %b", tag, k, busy, eb);
         end
         total++;
         if (done !== ed) begin
            bad++;
            $display("FAIL %s done k=%0d: got %b want %b", tag, k, done, ed);
         end
         total++;
         if (stim !== est) begin
            bad++;
            $display("FAIL %s stim k=%0d: got %h want %h", tag, k, stim, est);
         end
         start = 1'b0;
         if (k == intr_k) begin
            start = 1'b1; seed = ~s; cycles = cyc + 5; mode = m + 2'd1;
         end
         r = fix_resp ? 64'h00000001_00000003 : {$urandom, $urandom};
         resp = r;
         if (ap) esig = {esig[30:0], esig[31]} ^ r[31:0] ^ r[63:32];
         if (k < last_k) @(negedge clk);
      end
      start = 1'b0;
      total++;
      if (signature !== esig) begin
         bad++;
         $display("FAIL %s signature: got %h want %h", tag, signature, esig);
      end
      total++;
      if (cyc_cnt !== 32'(cyc)) begin
         bad++;
         $display("FAIL %s cyc_cnt final: got %0d want %0d", tag, cyc_cnt, cyc);
      end
      last_stim = est;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; seed = '0; cycles = '0; mode = '0; resp = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({stim, stim_valid, busy, done, cyc_cnt, signature} !== '0) begin
         bad++;
         $display("FAIL reset outputs: got %h/%b/%b/%b/%h/%h want all zero",
                  stim, stim_valid, busy, done, cyc_cnt, signature);
      end
      rst = 1'b0;
      last_stim = '0;
   endtask

   task automatic test_first_frame();
      do_run(32'h0, 2'd0, 1, 1'b0, 0, "first_frame");
      total++;
      if (stim !== 40'h7E_00003039) begin
         bad++;
         $display("FAIL first_frame stim: got %h want %h", stim, 40'h7E_00003039);
      end
   endtask

   task automatic test_walking();
      do_run($urandom, 2'd1, 3, 1'b0, 0, "walking");
      total++;
      if (stim !== 40'h4) begin
         bad++;
         $display("FAIL walking last stim: got %h want %h", stim, 40'h4);
      end
      do_run($urandom, 2'd1, 42, 1'b0, 0, "walk_wrap");
   endtask

   task automatic test_signature();
      do_run($urandom, 2'd0, 1, 1'b1, 0, "sig_one");
      total++;
      if (signature !== 32'h2) begin
         bad++;
         $display("FAIL sig_one: got %h want %h", signature, 32'h2);
      end
      do_run($urandom, 2'd2, 2, 1'b1, 0, "sig_two");
      total++;
      if (signature !== 32'h6) begin
         bad++;
         $display("FAIL sig_two: got %h want %h", signature, 32'h6);
      end
   endtask

   task automatic test_zero_cycles();
      do_run($urandom, 2'd0, 0, 1'b0, 0, "zero_cycles");
   endtask

   task automatic test_midrun_reset();
      @(negedge clk);
      seed = $urandom; mode = 2'd0; cycles = 4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({stim, stim_valid, busy, done, cyc_cnt, signature} !== '0) begin
         bad++;
         $display("FAIL midrun_reset outputs: got %h/%b/%b/%b/%h/%h want all zero",
                  stim, stim_valid, busy, done, cyc_cnt, signature);
      end
      start = 1'b1; cycles = 2;
      @(negedge clk);
      total++;
      if ({busy, done} !== 2'b00) begin
         bad++;
         $display("FAIL start_with_rst busy/done: got %b want %b", {busy, done}, 2'b00);
      end
      start = 1'b0;
      rst   = 1'b0;
      last_stim = '0;
      do_run(32'h0, 2'd0, 1, 1'b0, 0, "after_reset");
      total++;
      if (stim !== 40'h7E_00003039) begin
         bad++;
         $display("FAIL after_reset stim: got %h want %h", stim, 40'h7E_00003039);
      end
   endtask

   task automatic test_busy_start();
      do_run($urandom, 2'd0, 3, 1'b0, 2, "busy_start_fill");
      do_run($urandom, 2'd1, 2, 1'b0, 3, "busy_start_apply");
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         do_run($urandom, 2'($urandom_range(0, 3)), $urandom_range(1, 7), 1'b0, 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_walking();
      test_signature();
      test_zero_cycles();
      test_midrun_reset();
      test_busy_start();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
